// File: rtl/diferencial_receptor_lanes_if.sv
// Differential receiver lane bundle: per-lane D+/D- inputs, global enable,
// and the decoded bit / symbol-valid / electrical-idle outputs.
// master drives the line and the enable; slave is the receiver.
interface diferencial_receptor_lanes_if #(
    parameter int LANES = 1
) ();
    logic             enb;
    logic [LANES-1:0] dp;
    logic [LANES-1:0] dn;
    logic [LANES-1:0] salida;
    logic [LANES-1:0] valido;
    logic [LANES-1:0] rx_elec_idle;

    modport master (
        output enb,
        output dp,
        output dn,
        input  salida,
        input  valido,
        input  rx_elec_idle
    );

    modport slave (
        input  enb,
        input  dp,
        input  dn,
        output salida,
        output valido,
        output rx_elec_idle
    );
endinterface

// File: rtl/diferencial_receptor_lanes.sv
// Clocked multi-lane differential receiver.
// Each lane registers its D+/D- pair, classifies the sample (valid when
// dp != dn, bit = dp), and runs an IDLE/EXIT/ACTIVE state machine that
// debounces electrical-idle entry and exit. In ACTIVE each valid sample
// yields salida = bit XOR previous valid bit with valido = 1.
// Latency: input stable before edge n appears on the outputs after edge n+1.
// Optional build macro DIFRX_SYNC_EN: inserts a two-flop synchronizer per
// dp/dn bit ahead of stage 1 (two extra cycles of latency).
module diferencial_receptor_lanes #(
    parameter int LANES       = 1,
    parameter int IDLE_CYCLES = 4,
    parameter int EXIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    diferencial_receptor_lanes_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_TGT = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] EXIT_TGT = CNT_W'(EXIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [LANES-1:0] w_dp_in;
    logic [LANES-1:0] w_dn_in;
    logic [LANES-1:0] r_dp_q;
    logic [LANES-1:0] r_dn_q;

`ifdef DIFRX_SYNC_EN
    logic [LANES-1:0] r_dp_s1;
    logic [LANES-1:0] r_dp_s2;
    logic [LANES-1:0] r_dn_s1;
    logic [LANES-1:0] r_dn_s2;

    // two-flop synchronizer on every dp/dn bit, frozen by enb like the rest
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_s1 <= '0;
            r_dp_s2 <= '0;
            r_dn_s1 <= '0;
            r_dn_s2 <= '0;
        end else if (bus.enb) begin
            r_dp_s1 <= bus.dp;
            r_dp_s2 <= r_dp_s1;
            r_dn_s1 <= bus.dn;
            r_dn_s2 <= r_dn_s1;
        end
    end

    assign w_dp_in = r_dp_s2;
    assign w_dn_in = r_dn_s2;
`else
    assign w_dp_in = bus.dp;
    assign w_dn_in = bus.dn;
`endif

    // stage 1: capture the line pair for evaluation on the following edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_q <= '0;
            r_dn_q <= '0;
        end else if (bus.enb) begin
            r_dp_q <= w_dp_in;
            r_dn_q <= w_dn_in;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             r_prev;
        logic             w_prev_nxt;
        logic             r_salida;
        logic             w_salida_nxt;
        logic             r_valido;
        logic             w_valido_nxt;
        logic             r_idle;
        logic             w_idle_nxt;
        logic             w_valid;
        logic             w_bit;

        assign w_valid   = r_dp_q[g] ^ r_dn_q[g];
        assign w_bit     = r_dp_q[g];
        // debounce counter saturates instead of wrapping
        assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

        // stage 2 state, counter, previous bit and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_prev   <= 1'b0;
                r_salida <= 1'b0;
                r_valido <= 1'b0;
                r_idle   <= 1'b1;
            end else if (bus.enb) begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_prev   <= w_prev_nxt;
                r_salida <= w_salida_nxt;
                r_valido <= w_valido_nxt;
                r_idle   <= w_idle_nxt;
            end
        end

        // next-state decode; rx_elec_idle follows the state being entered
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_prev_nxt   = r_prev;
            w_salida_nxt = 1'b0;
            w_valido_nxt = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_prev_nxt = w_bit;
                        if (EXIT_CYCLES == 1) begin
                            w_state_nxt = ST_ACTIVE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_EXIT;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ST_EXIT: begin
                    if (w_valid) begin
                        w_prev_nxt = w_bit;
                        if (w_cnt_inc >= EXIT_TGT) begin
                            w_state_nxt = ST_ACTIVE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_valid) begin
                        w_valido_nxt = 1'b1;
                        w_salida_nxt = w_bit ^ r_prev;
                        w_prev_nxt   = w_bit;
                        w_cnt_nxt    = '0;
                    end else if (w_cnt_inc >= IDLE_TGT) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            w_idle_nxt = (w_state_nxt != ST_ACTIVE);
        end

        assign bus.salida[g]       = r_salida;
        assign bus.valido[g]       = r_valido;
        assign bus.rx_elec_idle[g] = r_idle;
    end

endmodule

// File: tb/tb_diferencial_receptor_lanes.sv
// Self-checking bench for diferencial_receptor_lanes (LANES=2, IDLE=4, EXIT=2).
// A behavioural lane model pushes the expected {salida,valido,rx_elec_idle}
// into a scoreboard queue as each input is driven; every scenario pops and
// compares after the edge. Directed scenarios also carry hand-derived
// expectations for the default (no synchronizer) build.
module tb_diferencial_receptor_lanes;

    localparam int IDLE_N = 4;
    localparam int EXIT_N = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    logic [5:0] sb [$];

    int         m_st  [2];
    int         m_cnt [2];
    logic [1:0] m_prev, m_dq, m_nq, m_sal, m_val, m_idle;
    logic [1:0] m_s1p, m_s1n, m_s2p, m_s2n;

    always #5 clk = ~clk;

    diferencial_receptor_lanes_if #(.LANES(2)) bus ();

    diferencial_receptor_lanes #(
        .LANES(2),
        .IDLE_CYCLES(IDLE_N),
        .EXIT_CYCLES(EXIT_N),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // drive one cycle of stimulus, advance the model, queue its expectation
    task automatic drive(input logic r, input logic e, input logic [1:0] p, input logic [1:0] n);
        rst = r; bus.enb = e; bus.dp = p; bus.dn = n;
        if (r) begin
            for (int l = 0; l < 2; l++) begin
                m_st[l] = 0; m_cnt[l] = 0;
            end
            m_prev = '0; m_dq = '0; m_nq = '0; m_sal = '0; m_val = '0; m_idle = '1;
            m_s1p = '0; m_s1n = '0; m_s2p = '0; m_s2n = '0;
        end else if (e) begin
            for (int l = 0; l < 2; l++) begin
                logic v, b;
                v = (m_dq[l] != m_nq[l]);
                b = m_dq[l];
                m_sal[l] = 1'b0;
                m_val[l] = 1'b0;
                if (m_st[l] == 2) begin
                    if (v) begin
                        m_val[l] = 1'b1; m_sal[l] = b ^ m_prev[l]; m_prev[l] = b; m_cnt[l] = 0;
                    end else begin
                        m_cnt[l]++;
                        if (m_cnt[l] == IDLE_N) begin m_st[l] = 0; m_cnt[l] = 0; end
                    end
                end else if (v) begin
                    m_prev[l] = b;
                    m_cnt[l] = (m_st[l] == 0) ? 1 : m_cnt[l] + 1;
                    if (m_cnt[l] >= EXIT_N) begin m_st[l] = 2; m_cnt[l] = 0; end
                    else m_st[l] = 1;
                end else begin
                    m_st[l] = 0; m_cnt[l] = 0;
                end
                m_idle[l] = (m_st[l] != 2);
            end
`ifdef DIFRX_SYNC_EN
            m_dq = m_s2p; m_nq = m_s2n;
            m_s2p = m_s1p; m_s2n = m_s1n;
            m_s1p = p; m_s1n = n;
`else
            m_dq = p; m_nq = n;
`endif
        end
        sb.push_back({m_sal[1], m_sal[0], m_val[1], m_val[0], m_idle[1], m_idle[0]});
        @(posedge clk);
        #1;
    endtask

    // table row: {rst, enb, dp[1:0], dn[1:0], expected {salida,valido,idle}}
    task automatic test_reset();
        logic [11:0] t [3] = '{12'b1_1_11_00_000011, 12'b1_1_11_00_000011, 12'b0_1_00_00_000011};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL reset_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL reset_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    task automatic test_idle_exit();
        logic [11:0] t [4] = '{12'b0_1_01_00_000011, 12'b0_1_01_00_000011,
                               12'b0_1_00_01_000010, 12'b0_1_01_00_010110};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL idle_exit_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL idle_exit_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    task automatic test_steady_data();
        logic [11:0] t [5] = '{12'b0_1_01_00_010110, 12'b0_1_01_00_000110, 12'b0_1_00_01_000110,
                               12'b0_1_00_01_010110, 12'b0_1_01_00_000110};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL steady_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL steady_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    task automatic test_glitch();
        logic [11:0] t [5] = '{12'b0_1_01_01_010110, 12'b0_1_01_01_000010, 12'b0_1_01_01_000010,
                               12'b0_1_00_01_000010, 12'b0_1_00_00_010110};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL glitch_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL glitch_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    task automatic test_idle_entry();
        logic [11:0] t [6] = '{12'b0_1_00_00_000010, 12'b0_1_00_00_000010, 12'b0_1_00_00_000010,
                               12'b0_1_01_00_000011, 12'b0_1_00_00_000011, 12'b0_1_00_00_000011};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL idle_entry_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL idle_entry_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    task automatic test_enable_reset();
        logic [11:0] t [11] = '{12'b0_1_01_00_000011, 12'b0_1_01_00_000011, 12'b0_1_00_01_000010,
                                12'b0_0_01_00_000010, 12'b0_0_00_01_000010, 12'b0_0_01_01_000010,
                                12'b0_1_01_00_010110, 12'b0_1_01_00_010110, 12'b1_1_01_00_000011,
                                12'b1_0_01_00_000011, 12'b0_1_01_00_000011};
        logic [5:0]  x, obs;
        foreach (t[i]) begin
            drive(t[i][11], t[i][10], t[i][9:8], t[i][7:6]);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL enb_rst_model[%0d] got %b want %b", i, obs, x); end
`ifndef DIFRX_SYNC_EN
            n_run++;
            if (obs !== t[i][5:0]) begin n_fail++; $display("FAIL enb_rst_hand[%0d] got %b want %b", i, obs, t[i][5:0]); end
`endif
        end
    endtask

    // both lanes independently random, mostly-valid symbols, sparse enb/rst
    task automatic test_random_lanes();
        logic [5:0] x, obs;
        logic [1:0] p, n;
        logic       r, e;
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < 2; l++) begin
                p[l] = 1'($urandom_range(0, 1));
                n[l] = ($urandom_range(0, 9) < 7) ? ~p[l] : p[l];
            end
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) != 0);
            drive(r, e, p, n);
            obs = {bus.salida, bus.valido, bus.rx_elec_idle};
            x = sb.pop_front();
            n_run++;
            if (obs !== x) begin n_fail++; $display("FAIL random[%0d] got %b want %b", i, obs, x); end
        end
    endtask

    initial begin
        rst = 1'b1; bus.enb = 1'b1; bus.dp = '0; bus.dn = '0;
        #2;
        test_reset();
        test_idle_exit();
        test_steady_data();
        test_glitch();
        test_idle_entry();
        test_enable_reset();
        test_random_lanes();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/diferencial_receptor_lanes.md
Name: diferencial_receptor_lanes

Overview:
- Clocked, multi-lane successor of the combinational differential receiver in the PHY receive path.
- Per lane: samples the D+/D- pair and decodes transitions into a serial bit stream (1 = line toggled, 0 = no toggle).
- Also per lane: flags valid symbols and detects electrical idle (D+ == D-) with debounced entry and exit.
- Feeds the downstream deserializer; its rx_elec_idle output drives the link-state logic.

Parameters:
- LANES, 1: number of independent differential lanes.
- IDLE_CYCLES, 4: consecutive invalid samples (dp == dn) required to enter electrical idle; must be >= 1.
- EXIT_CYCLES, 2: consecutive valid samples (dp != dn) required to leave electrical idle; must be >= 1.
- CNT_W, 4: debounce counter width; 2^CNT_W - 1 must be >= max(IDLE_CYCLES, EXIT_CYCLES).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high; takes priority over enb.
- enb  input  1  global enable; when 0 every register holds its value.
- dp  input  LANES  D+ per lane.
- dn  input  LANES  D- per lane.
- salida  output  LANES  decoded bit: 1 when the current valid bit differs from the previous valid bit.
- valido  output  LANES  1 when salida carries a decoded symbol.
- rx_elec_idle  output  LANES  1 while the lane is in electrical idle.

Behaviour:
- Interface decisions: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: salida=0, valido=0, rx_elec_idle=1, every lane state=IDLE, counters=0, prev_bit=0, stage-1 registers=0.
- Pipeline, per lane:
  - Stage 1 registers dp/dn at edge n.
  - Stage 2 evaluates that sample at edge n+1 and updates the outputs.
  - Input stable before edge n is therefore visible on outputs after edge n+1 (2-edge latency).
- Sample classification: valid when dp_q != dn_q, with bit = dp_q. Invalid when dp_q == dn_q (both 0 or both 1).
- FSM per lane: IDLE, EXIT, ACTIVE.
  - IDLE: rx_elec_idle=1, valido=0, salida=0.
    - Valid sample: cnt=1, prev_bit=bit; if EXIT_CYCLES==1 go ACTIVE, else go EXIT.
    - Invalid sample: stay, cnt=0.
  - EXIT: rx_elec_idle=1, valido=0, salida=0.
    - Valid sample: prev_bit=bit, cnt+1; when cnt reaches EXIT_CYCLES go ACTIVE with cnt=0.
    - Invalid sample: back to IDLE, cnt=0.
  - ACTIVE: rx_elec_idle=0.
    - Valid sample: valido=1, salida=bit XOR prev_bit, prev_bit=bit, cnt=0.
    - Invalid sample: valido=0, salida=0, prev_bit held, cnt+1; when cnt reaches IDLE_CYCLES go IDLE with rx_elec_idle=1 and cnt=0.
- Samples consumed in IDLE/EXIT never assert valido.
- The first ACTIVE symbol is decoded against the last EXIT bit.
- Counters saturate and never wrap.
- Lanes are fully independent; no cross-lane alignment.
- enb=0: stage 1, FSM, counters and outputs all hold. Samples presented while enb=0 are lost.
- rst mid-stream: all lanes return to reset values on the next edge regardless of state or enb.

Optional Feature:
- Macro DIFRX_SYNC_EN.
- Defined: a two-flop synchronizer per dp/dn bit sits ahead of stage 1. It resets to 0, obeys enb, and adds 2 cycles of latency (input at edge n reaches outputs after edge n+3).
- Undefined: no synchronizer; latency is as above.

Test Plan (LANES=2, IDLE_CYCLES=4, EXIT_CYCLES=2):
- Reset: rst=1 for 2 cycles with dp=2'b11, dn=2'b00 -> after release, outputs are salida=0, valido=0, rx_elec_idle=2'b11 until the exit count completes.
- Idle exit: lane0 dp/dn = 1/0, 1/0, then 0/1, 1/0 -> rx_elec_idle[0] falls after the 2nd sample is evaluated. Then valido[0]=1 with salida[0]=1, then 1.
- Steady data: lane0 in ACTIVE with bits 1,1,0,0,1 -> salida[0] = 0,0,1,0,1 with valido[0]=1 each cycle. Lane1 held at dp=dn=0 stays idle.
- Short glitch: in ACTIVE, 3 samples of dp=dn=1, then valid bit 0 after prev_bit=1 -> rx_elec_idle stays 0 and valido=0 for 3 cycles, then salida=1 with valido=1.
- Idle entry: 4 consecutive dp=dn=0 samples -> rx_elec_idle[0]=1 after the 4th sample is evaluated; the next single valid sample yields no valido.
- Enable and reset: enb=0 for 3 cycles while inputs toggle -> outputs frozen. rst pulsed while ACTIVE -> next edge gives rx_elec_idle=1, valido=0.
